// File: rtl/urv_dm_arbiter.sv
// Two-master arbiter for the shared data-memory port (CPU execute = m0, host/debug = m1).
// Latency: grant registered one cycle after request; dm_* and ready are combinational from the granted master/slave.
// Backpressure: masters hold requests until ready_o; slave stalls via dm_ready_i, aborted after TIMEOUT cycles (URV_DM_ARB_RR_EN selects round robin).
module urv_dm_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_s_i,
    input  logic [3:0]  m0_data_select_i,
    input  logic        m0_load_i,
    input  logic        m0_store_i,
    output logic        m0_ready_o,
    output logic        m0_error_o,
    output logic [31:0] m0_data_l_o,

    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_s_i,
    input  logic [3:0]  m1_data_select_i,
    input  logic        m1_load_i,
    input  logic        m1_store_i,
    output logic        m1_ready_o,
    output logic        m1_error_o,
    output logic [31:0] m1_data_l_o,

    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_data_s_o,
    output logic [3:0]  dm_data_select_o,
    output logic        dm_load_o,
    output logic        dm_store_o,
    input  logic        dm_ready_i,
    input  logic [31:0] dm_data_l_i,

    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam bit          TMO_EN   = (TIMEOUT != 0);
    localparam logic [15:0] TMO_LAST = TMO_EN ? 16'(TIMEOUT - 1) : 16'd0;

    state_t      state;
    logic [15:0] tmo_cnt;
    logic        last_grant;

    logic req0, req1;
    logic g0, g1;
    logic act;
    logic tmo;
    logic fin;
    logic win1;

    assign req0 = m0_load_i | m0_store_i;
    assign req1 = m1_load_i | m1_store_i;
    assign g0   = (state == GRANT0);
    assign g1   = (state == GRANT1);

    // A granted master that withdrew its request is not active: no ready, no timeout.
    assign act  = (g0 & req0) | (g1 & req1);
    assign tmo  = TMO_EN & act & ~dm_ready_i & (tmo_cnt == TMO_LAST);
    assign fin  = act & (dm_ready_i | tmo);

`ifdef URV_DM_ARB_RR_EN
    assign win1 = req1 & (~req0 | ~last_grant);
`else
    assign win1 = req1 & ~req0;
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    always_comb begin
        dm_addr_o        = 32'd0;
        dm_data_s_o      = 32'd0;
        dm_data_select_o = 4'd0;
        dm_load_o        = 1'b0;
        dm_store_o       = 1'b0;
        case (state)
            GRANT0: begin
                dm_addr_o        = m0_addr_i;
                dm_data_s_o      = m0_data_s_i;
                dm_data_select_o = m0_data_select_i;
                dm_load_o        = m0_load_i;
                dm_store_o       = m0_store_i;
            end
            GRANT1: begin
                dm_addr_o        = m1_addr_i;
                dm_data_s_o      = m1_data_s_i;
                dm_data_select_o = m1_data_select_i;
                dm_load_o        = m1_load_i;
                dm_store_o       = m1_store_i;
            end
            default: ;
        endcase
    end

    assign m0_ready_o  = g0 & fin;
    assign m1_ready_o  = g1 & fin;
    assign m0_error_o  = g0 & tmo;
    assign m1_error_o  = g1 & tmo;
    assign m0_data_l_o = dm_data_l_i;
    assign m1_data_l_o = dm_data_l_i;
    assign busy_o      = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            tmo_cnt    <= 16'd0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        state      <= win1 ? GRANT1 : GRANT0;
                        last_grant <= win1;
                        tmo_cnt    <= 16'd0;
                    end
                end
                GRANT0, GRANT1: begin
                    if (!act || fin) begin
                        state <= IDLE;
                    end
                    if (!dm_ready_i) begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_urv_dm_arbiter.sv
// Scoreboarded bench for urv_dm_arbiter: instance a (TIMEOUT=4) for arbitration/timeout, instance b (TIMEOUT=0) for the long wait.
// Completions are queued as expected by the stimulus and checked by an independent monitor on instance a.
module tb_urv_dm_arbiter;

    typedef struct packed {
        logic        load;
        logic        store;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
    } mreq_t;

    typedef struct packed {
        logic [1:0]  rdy;
        logic        err;
        logic        chk;
        logic [31:0] dat;
    } exp_t;

    localparam logic [31:0] KEY = 32'hDEADBFEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mreq_t m0_a, m1_a, m0_b, m1_b;
    logic        rdy_a = 1'b0, rdy_b = 1'b0;
    logic [31:0] dl_a = 32'd0, dl_b = 32'd0;

    logic        a_m0_ready, a_m0_error, a_m1_ready, a_m1_error;
    logic [31:0] a_m0_dl, a_m1_dl, a_dm_addr, a_dm_data_s;
    logic [3:0]  a_dm_sel;
    logic        a_dm_load, a_dm_store, a_busy;

    logic        b_m0_ready, b_m0_error, b_m1_ready, b_m1_error;
    logic [31:0] b_m0_dl, b_m1_dl, b_dm_addr, b_dm_data_s;
    logic [3:0]  b_dm_sel;
    logic        b_dm_load, b_dm_store, b_busy;

    urv_dm_arbiter #(.TIMEOUT(4)) u_a (
        .clk_i(clk), .rst_i(rst),
        .m0_addr_i(m0_a.addr), .m0_data_s_i(m0_a.data), .m0_data_select_i(m0_a.sel),
        .m0_load_i(m0_a.load), .m0_store_i(m0_a.store),
        .m0_ready_o(a_m0_ready), .m0_error_o(a_m0_error), .m0_data_l_o(a_m0_dl),
        .m1_addr_i(m1_a.addr), .m1_data_s_i(m1_a.data), .m1_data_select_i(m1_a.sel),
        .m1_load_i(m1_a.load), .m1_store_i(m1_a.store),
        .m1_ready_o(a_m1_ready), .m1_error_o(a_m1_error), .m1_data_l_o(a_m1_dl),
        .dm_addr_o(a_dm_addr), .dm_data_s_o(a_dm_data_s), .dm_data_select_o(a_dm_sel),
        .dm_load_o(a_dm_load), .dm_store_o(a_dm_store),
        .dm_ready_i(rdy_a), .dm_data_l_i(dl_a), .busy_o(a_busy)
    );

    urv_dm_arbiter #(.TIMEOUT(0)) u_b (
        .clk_i(clk), .rst_i(rst),
        .m0_addr_i(m0_b.addr), .m0_data_s_i(m0_b.data), .m0_data_select_i(m0_b.sel),
        .m0_load_i(m0_b.load), .m0_store_i(m0_b.store),
        .m0_ready_o(b_m0_ready), .m0_error_o(b_m0_error), .m0_data_l_o(b_m0_dl),
        .m1_addr_i(m1_b.addr), .m1_data_s_i(m1_b.data), .m1_data_select_i(m1_b.sel),
        .m1_load_i(m1_b.load), .m1_store_i(m1_b.store),
        .m1_ready_o(b_m1_ready), .m1_error_o(b_m1_error), .m1_data_l_o(b_m1_dl),
        .dm_addr_o(b_dm_addr), .dm_data_s_o(b_dm_data_s), .dm_data_select_o(b_dm_sel),
        .dm_load_o(b_dm_load), .dm_store_o(b_dm_store),
        .dm_ready_i(rdy_b), .dm_data_l_i(dl_b), .busy_o(b_busy)
    );

    int total = 0;
    int bad   = 0;
    exp_t  sb[$];
    mreq_t q0[$], q1[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mreq_t mk(input logic ld, input logic st, input logic [31:0] ad,
                                 input logic [31:0] dt, input logic [3:0] sl);
        mreq_t r;
        r.load = ld; r.store = st; r.addr = ad; r.data = dt; r.sel = sl;
        return r;
    endfunction

    function automatic exp_t ex(input logic [1:0] r, input logic e, input logic c, input logic [31:0] d);
        exp_t x;
        x.rdy = r; x.err = e; x.chk = c; x.dat = d;
        return x;
    endfunction

    // Slave models: respond after wait_* stall cycles, load data = addr ^ KEY.
    int          wait_a = 0, wcnt_a = 0, st_cyc_a = 0;
    logic [31:0] st_dat_a = 32'd0;
    logic [3:0]  st_sel_a = 4'd0;
    always @(negedge clk) begin
        if (a_dm_load | a_dm_store) begin
            if (a_dm_store) begin
                st_cyc_a++;
                st_dat_a = a_dm_data_s;
                st_sel_a = a_dm_sel;
            end
            if (wcnt_a >= wait_a) begin
                rdy_a = 1'b1;
                dl_a  = a_dm_addr ^ KEY;
            end else begin
                rdy_a = 1'b0;
                wcnt_a++;
            end
        end else begin
            rdy_a  = 1'b0;
            wcnt_a = 0;
        end
    end

    int wait_b = 0, wcnt_b = 0;
    always @(negedge clk) begin
        if (b_dm_load | b_dm_store) begin
            if (wcnt_b >= wait_b) begin
                rdy_b = 1'b1;
                dl_b  = b_dm_addr ^ KEY;
            end else begin
                rdy_b = 1'b0;
                wcnt_b++;
            end
        end else begin
            rdy_b  = 1'b0;
            wcnt_b = 0;
        end
    end

    always begin
        @(negedge clk);
        #1;
        if (a_m0_ready | a_m1_ready) begin
            if (sb.size() == 0) begin
                check("spurious_ready", 64'({a_m1_ready, a_m0_ready}), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_ready", 64'({a_m1_ready, a_m0_ready}), 64'(e.rdy));
                check("sb_error", 64'({a_m1_error, a_m0_error}), 64'(e.err ? e.rdy : 2'b00));
                if (e.chk) begin
                    check("sb_m0_data", 64'(a_m0_dl), 64'(e.dat));
                    check("sb_m1_data", 64'(a_m1_dl), 64'(e.dat));
                end
            end
        end else if (a_m0_error | a_m1_error) begin
            check("error_without_ready", 64'({a_m1_error, a_m0_error}), 64'd0);
        end
    end

    task automatic tick_drive;
        @(posedge clk);
        #2;
    endtask

    task automatic at_neg;
        @(negedge clk);
        #1;
    endtask

    task automatic next_cyc;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_dm_load"},  64'(a_dm_load),   64'd0);
        check({tag, "_dm_store"}, 64'(a_dm_store),  64'd0);
        check({tag, "_dm_addr"},  64'(a_dm_addr),   64'd0);
        check({tag, "_dm_dat_s"}, 64'(a_dm_data_s), 64'd0);
        check({tag, "_dm_sel"},   64'(a_dm_sel),    64'd0);
        check({tag, "_ready"},    64'({a_m1_ready, a_m0_ready}), 64'd0);
        check({tag, "_error"},    64'({a_m1_error, a_m0_error}), 64'd0);
        check({tag, "_busy"},     64'(a_busy),      64'd0);
    endtask

    task automatic do_reset;
        tick_drive();
        rst  = 1'b1;
        m0_a = '0; m1_a = '0; m0_b = '0;
        repeat (2) tick_drive();
        rst = 1'b0;
        at_neg();
    endtask

    // Each master keeps presenting its queued requests back to back until drained.
    task automatic run_masters(input int budget);
        int  n;
        bit  act0, act1, seen0, seen1;
        tick_drive();
        act0 = (q0.size() != 0);
        act1 = (q1.size() != 0);
        m0_a = act0 ? q0.pop_front() : '0;
        m1_a = act1 ? q1.pop_front() : '0;
        n = 0;
        while ((act0 || act1) && n < budget) begin
            at_neg();
            seen0 = act0 && a_m0_ready;
            seen1 = act1 && a_m1_ready;
            tick_drive();
            if (seen0) begin
                if (q0.size() != 0) m0_a = q0.pop_front();
                else begin m0_a = '0; act0 = 1'b0; end
            end
            if (seen1) begin
                if (q1.size() != 0) m1_a = q1.pop_front();
                else begin m1_a = '0; act1 = 1'b0; end
            end
            n++;
        end
        check("run_within_budget", 64'(n < budget), 64'd1);
        m0_a = '0; m1_a = '0;
    endtask

    initial begin
        int got;
        logic gerr;
        logic [31:0] gdat;
        int st_before;

        m0_a = '0; m1_a = '0; m0_b = '0; m1_b = '0;
        repeat (2) @(posedge clk);
        at_neg();
        check_idle_outputs("in_reset");
        do_reset();
        check_idle_outputs("after_reset");
        check("after_reset_b_busy", 64'(b_busy), 64'd0);

        // Single zero-wait load from m0.
        wait_a = 0;
        tick_drive();
        m0_a = mk(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
        sb.push_back(ex(2'b01, 1'b0, 1'b1, 32'hDEADBEEF));
        at_neg();
        check("single_c0_load", 64'(a_dm_load), 64'd0);
        next_cyc();
        check("single_c1_load", 64'(a_dm_load), 64'd1);
        check("single_c1_addr", 64'(a_dm_addr), 64'h100);
        check("single_c1_busy", 64'(a_busy), 64'd1);
        tick_drive();
        m0_a = '0;
        at_neg();
        check("single_c2_busy", 64'(a_busy), 64'd0);
        check("single_c2_load", 64'(a_dm_load), 64'd0);

        // Both masters requesting continuously.
        do_reset();
        q0.push_back(mk(1'b1, 1'b0, 32'h10, 32'h0, 4'hF));
        q0.push_back(mk(1'b1, 1'b0, 32'h14, 32'h0, 4'hF));
        q0.push_back(mk(1'b1, 1'b0, 32'h18, 32'h0, 4'hF));
        q1.push_back(mk(1'b1, 1'b0, 32'h20, 32'h0, 4'hF));
        q1.push_back(mk(1'b1, 1'b0, 32'h24, 32'h0, 4'hF));
`ifdef URV_DM_ARB_RR_EN
        sb.push_back(ex(2'b01, 1'b0, 1'b1, 32'h10 ^ KEY));
        sb.push_back(ex(2'b10, 1'b0, 1'b1, 32'h20 ^ KEY));
        sb.push_back(ex(2'b01, 1'b0, 1'b1, 32'h14 ^ KEY));
        sb.push_back(ex(2'b10, 1'b0, 1'b1, 32'h24 ^ KEY));
        sb.push_back(ex(2'b01, 1'b0, 1'b1, 32'h18 ^ KEY));
`else
        sb.push_back(ex(2'b01, 1'b0, 1'b1, 32'h10 ^ KEY));
        sb.push_back(ex(2'b01, 1'b0, 1'b1, 32'h14 ^ KEY));
        sb.push_back(ex(2'b01, 1'b0, 1'b1, 32'h18 ^ KEY));
        sb.push_back(ex(2'b10, 1'b0, 1'b1, 32'h20 ^ KEY));
        sb.push_back(ex(2'b10, 1'b0, 1'b1, 32'h24 ^ KEY));
`endif
        run_masters(100);

        // m1 store, 3 stall cycles: ready lands exactly on counter == TIMEOUT-1 and must not be an error.
        do_reset();
        wait_a = 3;
        st_before = st_cyc_a;
        q1.push_back(mk(1'b0, 1'b1, 32'h300, 32'h12345678, 4'b0011));
        sb.push_back(ex(2'b10, 1'b0, 1'b1, 32'h300 ^ KEY));
        run_masters(50);
        check("store_strobe_cycles", 64'(st_cyc_a - st_before), 64'd4);
        check("store_data", 64'(st_dat_a), 64'h12345678);
        check("store_sel", 64'(st_sel_a), 64'h3);

        // Timeout abort on the 4th granted cycle.
        do_reset();
        wait_a = 100000;
        tick_drive();
        m0_a = mk(1'b1, 1'b0, 32'h400, 32'h0, 4'hF);
        sb.push_back(ex(2'b01, 1'b1, 1'b0, 32'h0));
        got = 0;
        for (int k = 1; k <= 10; k++) begin
            next_cyc();
            if (a_m0_ready) begin
                got = k;
                check("timeout_strobe_held", 64'(a_dm_load), 64'd1);
                break;
            end
        end
        check("timeout_cycle", 64'(got), 64'd4);
        tick_drive();
        m0_a = '0;
        at_neg();
        check("timeout_idle_busy", 64'(a_busy), 64'd0);
        check("timeout_idle_load", 64'(a_dm_load), 64'd0);

        // Withdrawn request: strobe drops at once, FSM idles next cycle, no ready.
        do_reset();
        tick_drive();
        m0_a = mk(1'b1, 1'b0, 32'h500, 32'h0, 4'hF);
        next_cyc();
        check("withdraw_c1_busy", 64'(a_busy), 64'd1);
        tick_drive();
        m0_a = '0;
        at_neg();
        check("withdraw_c2_load", 64'(a_dm_load), 64'd0);
        check("withdraw_c2_busy", 64'(a_busy), 64'd1);
        next_cyc();
        check("withdraw_c3_busy", 64'(a_busy), 64'd0);

        // Reset during GRANT1: access dropped, outputs at reset values.
        do_reset();
        tick_drive();
        m1_a = mk(1'b1, 1'b0, 32'h600, 32'h0, 4'hF);
        next_cyc();
        check("rst_mid_c1_busy", 64'(a_busy), 64'd1);
        check("rst_mid_c1_addr", 64'(a_dm_addr), 64'h600);
        rst = 1'b1;
        next_cyc();
        check_idle_outputs("rst_mid");
        next_cyc();
        tick_drive();
        m1_a = '0;
        rst  = 1'b0;
        at_neg();
        check_idle_outputs("rst_mid_release");
        wait_a = 0;

        // TIMEOUT=0 instance: 999 stall cycles, completion on the 1000th granted cycle.
        wait_b = 999;
        tick_drive();
        m0_b = mk(1'b1, 1'b0, 32'h200, 32'h0, 4'hF);
        got = 0; gerr = 1'b0; gdat = 32'd0;
        for (int k = 1; k <= 1100; k++) begin
            next_cyc();
            if (b_m0_ready) begin
                got = k; gerr = b_m0_error; gdat = b_m0_dl;
                break;
            end
        end
        check("notmo_ready_cycle", 64'(got), 64'd1000);
        check("notmo_error", 64'(gerr), 64'd0);
        check("notmo_data", 64'(gdat), 64'(32'h200 ^ KEY));
        tick_drive();
        m0_b = '0;
        at_neg();
        check("notmo_idle_busy", 64'(b_busy), 64'd0);

        repeat (3) next_cyc();
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/urv_dm_arbiter.md
# urv_dm_arbiter

Two-master arbiter sharing the core's single data-memory port between the CPU execute stage (master 0) and a host/debug requester (master 1). It sits between the execute stage's dm_* interface and the data memory / peripheral bus. It registers the grant decision, muxes the winning master's address, data and strobes onto the slave port, routes ready back, and aborts accesses the slave never acknowledges.

## Interface
Parameters:
- TIMEOUT, 255: number of granted cycles without dm_ready_i before abort; 0 disables the timeout; must fit in 16 bits.

Ports:
- Single clock; synchronous, active-high reset.
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  synchronous reset, active high.
- m0_addr_i, m1_addr_i  in  32  byte address.
- m0_data_s_i, m1_data_s_i  in  32  store data.
- m0_data_select_i, m1_data_select_i  in  4  byte enables.
- m0_load_i, m1_load_i  in  1  load request, held until completion.
- m0_store_i, m1_store_i  in  1  store request, held until completion.
- m0_ready_o, m1_ready_o  out  1  completion strobe for that master.
- m0_error_o, m1_error_o  out  1  completion was a timeout abort; valid with ready.
- m0_data_l_o, m1_data_l_o  out  32  load data; both equal dm_data_l_i.
- dm_addr_o  out  32  slave address.
- dm_data_s_o  out  32  slave store data.
- dm_data_select_o  out  4  slave byte enables.
- dm_load_o, dm_store_o  out  1  slave strobes.
- dm_ready_i  in  1  slave completion.
- dm_data_l_i  in  32  slave load data, valid with dm_ready_i.
- busy_o  out  1  high in any GRANT state.

## Operation
- Request: a master asserts load or store with stable addr/data/select and holds it until its ready_o is high. A transfer completes in the cycle where the granted master's strobe and dm_ready_i are both 1. Load data is sampled in that same cycle.
- FSM states: IDLE, GRANT0, GRANT1.
  - IDLE: slave strobes 0, all ready/error 0. If any request is present, the next state is GRANTn for the arbitration winner.
  - GRANTn: dm_* outputs equal master n's inputs (combinational mux). mn_ready_o equals dm_ready_i. The other master's ready/error is 0.
  - On completion, or on timeout, the next state is IDLE.
- Arbitration in IDLE: fixed priority, master 0 wins, unless URV_DM_ARB_RR_EN is defined.
- last_grant register: updated to n on entry to GRANTn.
- Timeout counter (16 bit):
  - Cleared on entry to GRANTn; increments in each granted cycle without dm_ready_i.
  - In the granted cycle where counter == TIMEOUT-1 and dm_ready_i is 0, the arbiter asserts mn_ready_o=1 and mn_error_o=1. Slave strobes stay asserted that cycle. The next state is IDLE.
  - dm_ready_i arriving in that same cycle is a normal completion with error 0.
- Request withdrawn while granted (protocol violation): dm strobes follow the input and drop immediately; the FSM returns to IDLE the next cycle and no ready is issued.
- Both load and store asserted: both are forwarded unchanged; the slave defines the behaviour.
- dm_ready_i in IDLE or while no strobe is asserted: ignored.

## Timing
- Reset values:
  - state=IDLE, counter=0, last_grant=1.
  - dm_load_o=dm_store_o=0, dm_addr_o/dm_data_s_o/dm_data_select_o=0 (IDLE mux selects zero).
  - m*_ready_o=0, m*_error_o=0, busy_o=0.
- Arbitration latency: request first seen in cycle T → dm strobe asserted in T+1. With a zero-wait slave, ready arrives in T+1. Each access therefore occupies at least 2 cycles; back-to-back accesses by one master issue every 2 cycles.
- The completion cycle returns the FSM to IDLE at T+2. A pending request (either master) is re-arbitrated in that IDLE cycle.
- Reset asserted mid-access: the FSM is in IDLE on the next edge. The in-flight access is dropped with no ready to the master.
- Combinational paths: m*_ready_o from dm_ready_i; dm_* from m*_*_i.

## Configuration
- URV_DM_ARB_RR_EN defined: round robin. When both masters request in IDLE, the master ≠ last_grant wins. After reset (last_grant=1), master 0 wins first.
- Not defined: fixed priority, master 0 always wins. last_grant is still maintained but unused.

## Test plan
- Single load from m0, addr 0x100, slave ready immediately → dm_load_o=1 and dm_addr_o=0x100 in cycle 1; m0_ready_o=1 with m0_data_l_o=0xDEADBEEF in cycle 1; busy_o=0 in cycle 2.
- m0 and m1 both request continuously, zero-wait slave:
  - RR_EN: grants alternate 0,1,0,1.
  - Without RR_EN: only m0 is served while it keeps requesting; m1 is served after m0 drops.
- m1 store 0x12345678 sel 4'b0011, slave waits 3 cycles → dm_store_o held 4 cycles; m1_ready_o for one cycle only; m0_ready_o stays 0.
- TIMEOUT=4, slave never ready → m0_ready_o=1 and m0_error_o=1 in the 4th granted cycle; IDLE next cycle.
- TIMEOUT=0 with a 1000-cycle slave wait → no abort; ready at cycle 1000 with error 0.
- Reset asserted during GRANT1 → next cycle all outputs at reset values; m1_ready_o never pulses.
